// File: rtl/computer_system_pio_pkg.sv
// Shared definitions for the Computer_System PIO blocks: register word
// addresses, edge-capture encodings and a constant-time ceil(log2) helper.
package computer_system_pio_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  localparam int unsigned EDGE_RISING  = 0;
  localparam int unsigned EDGE_FALLING = 1;
  localparam int unsigned EDGE_ANY     = 2;

  // ceil(log2(value)); returns 0 for value <= 1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    int unsigned remaining;
    result = 0;
    if (value > 1) begin
      remaining = value - 1;
      while (remaining > 0) begin
        result    = result + 1;
        remaining = remaining >> 1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/pio_debounce.sv
// One input bit: 2-flop synchronizer followed by a consecutive-cycle
// debounce counter. 'update' is high in the cycle whose clock edge loads
// a new value into 'stable', so the new level is always ~stable then.
module pio_debounce
  import computer_system_pio_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic stable,
  output logic update
);

  logic sync1_reg;
  logic sync2_reg;
  logic stable_reg;

  // Bring the asynchronous pin into the clk domain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
    end else begin
      sync1_reg <= din;
      sync2_reg <= sync1_reg;
    end
  end

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
      // No filtering: the stable level tracks the synchronizer output.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          stable_reg <= 1'b0;
        end else begin
          stable_reg <= sync2_reg;
        end
      end
      assign update = (sync2_reg != stable_reg);
    end else begin : g_count
      localparam int unsigned CW = (clog2(DEBOUNCE_CYCLES) < 1) ? 1 : clog2(DEBOUNCE_CYCLES);
      localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
      logic [CW-1:0] count_reg;

      // Accept a new level only after it differs for DEBOUNCE_CYCLES cycles
      // in a row; any return to the stable level restarts the count.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          stable_reg <= 1'b0;
          count_reg  <= '0;
        end else if (sync2_reg == stable_reg) begin
          count_reg <= '0;
        end else if (count_reg == LAST) begin
          stable_reg <= sync2_reg;
          count_reg  <= '0;
        end else begin
          count_reg <= count_reg + 1'b1;
        end
      end
      assign update = (sync2_reg != stable_reg) && (count_reg == LAST);
    end
  endgenerate

  assign stable = stable_reg;

endmodule

// File: rtl/computer_system_keys_in.sv
// Avalon-MM input PIO: debounced key/switch levels, an edge-capture
// register with write-1-to-clear, an interrupt mask and a level irq.
module computer_system_keys_in
  import computer_system_pio_pkg::*;
#(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned EDGE_TYPE       = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] update;
  logic [WIDTH-1:0] edge_event;
  logic [WIDTH-1:0] irqmask_reg;
  logic [WIDTH-1:0] edgecap_reg;
  logic [WIDTH-1:0] edgecap_clear;
  logic             irq_reg;
  logic             wr_en;
  logic             unused_wdata;

  assign wr_en        = chipselect & ~write_n;
  // Upper write-data bits have no storage behind them.
  assign unused_wdata = ^writedata;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      pio_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debounce (
        .clk    (clk),
        .reset_n(reset_n),
        .din    (in_port[gi]),
        .stable (stable[gi]),
        .update (update[gi])
      );

      // On an update the incoming level is the complement of the current one.
      if (EDGE_TYPE == EDGE_ANY) begin : g_any
        assign edge_event[gi] = update[gi];
      end else if (EDGE_TYPE == EDGE_RISING) begin : g_rise
        assign edge_event[gi] = update[gi] & ~stable[gi];
      end else begin : g_fall
        assign edge_event[gi] = update[gi] & stable[gi];
      end
    end
  endgenerate

  assign edgecap_clear = (wr_en && address == ADDR_EDGECAP) ? writedata[WIDTH-1:0] : '0;

  // Mask register, edge capture (a new edge beats a same-cycle clear) and irq.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irqmask_reg <= '0;
      edgecap_reg <= '0;
      irq_reg     <= 1'b0;
    end else begin
      if (wr_en && address == ADDR_IRQMASK) begin
        irqmask_reg <= writedata[WIDTH-1:0];
      end
      edgecap_reg <= (edgecap_reg & ~edgecap_clear) | edge_event;
      irq_reg     <= |(edgecap_reg & irqmask_reg);
    end
  end

  // Zero-latency read mux; reserved word and unused high bits read 0.
  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:    readdata[WIDTH-1:0] = stable;
      ADDR_IRQMASK: readdata[WIDTH-1:0] = irqmask_reg;
      ADDR_EDGECAP: readdata[WIDTH-1:0] = edgecap_reg;
      default:      readdata = '0;
    endcase
  end

  assign irq = irq_reg;

endmodule

// File: tb/tb_computer_system_keys_in.sv
// Directed bench: instance a (N=4, falling edges) and instance b
// (debounce bypassed, any edge).
module tb_computer_system_keys_in;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;

  logic [1:0]  a_address = 2'd0;
  logic        a_chipselect = 1'b0;
  logic        a_write_n = 1'b1;
  logic [31:0] a_writedata = 32'd0;
  logic [31:0] a_readdata;
  logic [3:0]  a_in_port = 4'h0;
  logic        a_irq;

  logic [1:0]  b_address = 2'd0;
  logic        b_chipselect = 1'b0;
  logic        b_write_n = 1'b1;
  logic [31:0] b_writedata = 32'd0;
  logic [31:0] b_readdata;
  logic [3:0]  b_in_port = 4'h0;
  logic        b_irq;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  computer_system_keys_in #(.WIDTH(4), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(1)) u_dut_a (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (a_address),
    .chipselect(a_chipselect),
    .write_n   (a_write_n),
    .writedata (a_writedata),
    .readdata  (a_readdata),
    .in_port   (a_in_port),
    .irq       (a_irq)
  );

  computer_system_keys_in #(.WIDTH(4), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(2)) u_dut_b (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (b_address),
    .chipselect(b_chipselect),
    .write_n   (b_write_n),
    .writedata (b_writedata),
    .readdata  (b_readdata),
    .in_port   (b_in_port),
    .irq       (b_irq)
  );

  // Combinational read, issued at a falling edge.
  task automatic rd(input bit sel_b, input logic [1:0] addr, output logic [31:0] data);
    if (sel_b) begin
      b_address = addr;
      #1;
      data = b_readdata;
    end else begin
      a_address = addr;
      #1;
      data = a_readdata;
    end
  endtask

  // Single-cycle write, launched at a falling edge, taken at the next rising edge.
  task automatic wr(input bit sel_b, input logic [1:0] addr, input logic [31:0] data);
    if (sel_b) begin
      b_chipselect = 1'b1; b_write_n = 1'b0; b_address = addr; b_writedata = data;
    end else begin
      a_chipselect = 1'b1; a_write_n = 1'b0; a_address = addr; a_writedata = data;
    end
    @(negedge clk);
    a_chipselect = 1'b0; a_write_n = 1'b1;
    b_chipselect = 1'b0; b_write_n = 1'b1;
    $display("[TB] wr dut=%s addr=%0d data=%08h", sel_b ? "b" : "a", addr, data);
  endtask

  task automatic test_reset();
    logic [31:0] d;
    reset_n = 1'b0;
    a_in_port = 4'hF;
    b_in_port = 4'h0;
    repeat (3) @(negedge clk);
    rd(1'b0, 2'd0, d);
    tests_run++;
    if (d !== 32'h0) begin tests_failed++; $display("FAIL reset_data got=%08h exp=%08h", d, 32'h0); end
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    rd(1'b0, 2'd0, d);
    tests_run++;
    if (d !== 32'h0) begin tests_failed++; $display("FAIL reset_data_early got=%08h exp=%08h", d, 32'h0); end
    @(negedge clk);
    rd(1'b0, 2'd0, d);
    tests_run++;
    if (d !== 32'hF) begin tests_failed++; $display("FAIL reset_data_6cyc got=%08h exp=%08h", d, 32'hF); end
    rd(1'b0, 2'd3, d);
    tests_run++;
    if (d !== 32'h0) begin tests_failed++; $display("FAIL reset_edgecap got=%08h exp=%08h", d, 32'h0); end
    tests_run++;
    if (a_irq !== 1'b0) begin tests_failed++; $display("FAIL reset_irq got=%0b exp=0", a_irq); end
    $display("[TB] reset done");
  endtask

  task automatic test_bounce();
    logic [31:0] d;
    a_in_port = 4'hE;
    repeat (3) @(negedge clk);
    a_in_port = 4'hF;
    repeat (10) @(negedge clk);
    rd(1'b0, 2'd0, d);
    tests_run++;
    if (d !== 32'hF) begin tests_failed++; $display("FAIL bounce_data got=%08h exp=%08h", d, 32'hF); end
    rd(1'b0, 2'd3, d);
    tests_run++;
    if (d !== 32'h0) begin tests_failed++; $display("FAIL bounce_edgecap got=%08h exp=%08h", d, 32'h0); end
    $display("[TB] bounce done");
  endtask

  task automatic test_accept();
    logic [31:0] d;
    a_in_port = 4'hE;
    repeat (5) @(negedge clk);
    rd(1'b0, 2'd0, d);
    tests_run++;
    if (d !== 32'hF) begin tests_failed++; $display("FAIL accept_data_5cyc got=%08h exp=%08h", d, 32'hF); end
    @(negedge clk);
    rd(1'b0, 2'd0, d);
    tests_run++;
    if (d !== 32'hE) begin tests_failed++; $display("FAIL accept_data_6cyc got=%08h exp=%08h", d, 32'hE); end
    rd(1'b0, 2'd3, d);
    tests_run++;
    if (d !== 32'h1) begin tests_failed++; $display("FAIL accept_edgecap got=%08h exp=%08h", d, 32'h1); end
    repeat (2) @(negedge clk);
    tests_run++;
    if (a_irq !== 1'b0) begin tests_failed++; $display("FAIL accept_irq_masked got=%0b exp=0", a_irq); end
    $display("[TB] accept done");
  endtask

  task automatic test_irq();
    logic [31:0] d;
    wr(1'b0, 2'd2, 32'h1);
    tests_run++;
    if (a_irq !== 1'b0) begin tests_failed++; $display("FAIL irq_before got=%0b exp=0", a_irq); end
    @(negedge clk);
    tests_run++;
    if (a_irq !== 1'b1) begin tests_failed++; $display("FAIL irq_unmask got=%0b exp=1", a_irq); end
    wr(1'b0, 2'd3, 32'h1);
    rd(1'b0, 2'd3, d);
    tests_run++;
    if (d !== 32'h0) begin tests_failed++; $display("FAIL irq_clear_edgecap got=%08h exp=%08h", d, 32'h0); end
    @(negedge clk);
    tests_run++;
    if (a_irq !== 1'b0) begin tests_failed++; $display("FAIL irq_clear got=%0b exp=0", a_irq); end
    $display("[TB] irq done");
  endtask

  task automatic test_set_wins();
    logic [31:0] d;
    // bit0 rises (ignored), bit3 falls (captured)
    a_in_port = 4'h7;
    repeat (8) @(negedge clk);
    rd(1'b0, 2'd3, d);
    tests_run++;
    if (d !== 32'h8) begin tests_failed++; $display("FAIL setwins_pre_edgecap got=%08h exp=%08h", d, 32'h8); end
    // bit0 falls; clear bits 0 and 3 on the very edge bit0 updates
    a_in_port = 4'h6;
    repeat (5) @(negedge clk);
    wr(1'b0, 2'd3, 32'h9);
    rd(1'b0, 2'd3, d);
    tests_run++;
    if (d !== 32'h1) begin tests_failed++; $display("FAIL setwins_edgecap got=%08h exp=%08h", d, 32'h1); end
    rd(1'b0, 2'd0, d);
    tests_run++;
    if (d !== 32'h6) begin tests_failed++; $display("FAIL setwins_data got=%08h exp=%08h", d, 32'h6); end
    @(negedge clk);
    tests_run++;
    if (a_irq !== 1'b1) begin tests_failed++; $display("FAIL setwins_irq got=%0b exp=1", a_irq); end
    $display("[TB] set_wins done");
  endtask

  task automatic test_mask_regmap();
    logic [31:0] d;
    wr(1'b0, 2'd2, 32'h0);
    @(negedge clk);
    tests_run++;
    if (a_irq !== 1'b0) begin tests_failed++; $display("FAIL mask_irq_off got=%0b exp=0", a_irq); end
    rd(1'b0, 2'd3, d);
    tests_run++;
    if (d !== 32'h1) begin tests_failed++; $display("FAIL mask_keeps_edgecap got=%08h exp=%08h", d, 32'h1); end
    wr(1'b0, 2'd2, 32'hFFFF_FFF5);
    rd(1'b0, 2'd2, d);
    tests_run++;
    if (d !== 32'h5) begin tests_failed++; $display("FAIL mask_readback got=%08h exp=%08h", d, 32'h5); end
    @(negedge clk);
    tests_run++;
    if (a_irq !== 1'b1) begin tests_failed++; $display("FAIL mask_irq_on got=%0b exp=1", a_irq); end
    wr(1'b0, 2'd1, 32'hFFFF_FFFF);
    rd(1'b0, 2'd1, d);
    tests_run++;
    if (d !== 32'h0) begin tests_failed++; $display("FAIL reserved_read got=%08h exp=%08h", d, 32'h0); end
    wr(1'b0, 2'd0, 32'h0);
    rd(1'b0, 2'd0, d);
    tests_run++;
    if (d !== 32'h6) begin tests_failed++; $display("FAIL data_write_ignored got=%08h exp=%08h", d, 32'h6); end
    $display("[TB] mask_regmap done");
  endtask

  task automatic test_bypass();
    logic [31:0] d;
    b_in_port = 4'h4;
    repeat (2) @(negedge clk);
    rd(1'b1, 2'd0, d);
    tests_run++;
    if (d !== 32'h0) begin tests_failed++; $display("FAIL bypass_rise_early got=%08h exp=%08h", d, 32'h0); end
    @(negedge clk);
    rd(1'b1, 2'd0, d);
    tests_run++;
    if (d !== 32'h4) begin tests_failed++; $display("FAIL bypass_rise_data got=%08h exp=%08h", d, 32'h4); end
    rd(1'b1, 2'd3, d);
    tests_run++;
    if (d !== 32'h4) begin tests_failed++; $display("FAIL bypass_rise_edgecap got=%08h exp=%08h", d, 32'h4); end
    wr(1'b1, 2'd3, 32'h4);
    rd(1'b1, 2'd3, d);
    tests_run++;
    if (d !== 32'h0) begin tests_failed++; $display("FAIL bypass_clear got=%08h exp=%08h", d, 32'h0); end
    wr(1'b1, 2'd2, 32'h4);
    b_in_port = 4'h0;
    repeat (3) @(negedge clk);
    rd(1'b1, 2'd0, d);
    tests_run++;
    if (d !== 32'h0) begin tests_failed++; $display("FAIL bypass_fall_data got=%08h exp=%08h", d, 32'h0); end
    rd(1'b1, 2'd3, d);
    tests_run++;
    if (d !== 32'h4) begin tests_failed++; $display("FAIL bypass_fall_edgecap got=%08h exp=%08h", d, 32'h4); end
    @(negedge clk);
    tests_run++;
    if (b_irq !== 1'b1) begin tests_failed++; $display("FAIL bypass_irq got=%0b exp=1", b_irq); end
    $display("[TB] bypass done");
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_accept();
    test_irq();
    test_set_wins();
    test_mask_regmap();
    test_bypass();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
